// File: rtl/clk_div_bank_if.sv
// Divide-ratio load bus for clk_div_bank.
//   div_load : single-cycle load strobe (may be held for back-to-back loads)
//   div_sel  : target channel index
//   div_val  : new divide ratio
//   div_ack  : one-cycle pulse, the cycle after an accepted load
// master drives the load request, slave is the divider bank.
interface clk_div_bank_if #(
    parameter int NCH   = 2,
    parameter int DIV_W = 8
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             div_load;
    logic [SEL_W-1:0] div_sel;
    logic [DIV_W-1:0] div_val;
    logic             div_ack;

    modport master (output div_load, div_sel, div_val, input div_ack);
    modport slave  (input div_load, div_sel, div_val, output div_ack);
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank: free-running counter with synchronised snapshot capture,
// plus a bank of NCH programmable 50%-duty clock dividers.
//   clk_in      : single clock, everything on the rising edge
//   rst         : asynchronous active-high reset
//   sample_in   : asynchronous snapshot request (rising edge captures)
//   en          : count enable for the free-running counter
//   bus         : divide-ratio load bus (slave side)
//   clk_out     : registered divided clocks, one bit per channel
//   counter_out : last captured counter value
//   snap_valid  : one-cycle pulse marking a new counter_out
//   overflow    : sticky, set on the first counter wrap

// One divider channel. Ratio 0 parks the output low; ratio N toggles the
// output every N cycles, giving a period of 2N.
module clk_div_lane #(
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] val,
    output logic             clk_out
);
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] pc;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_r   <= DIV_W'(DIV_INIT);
            pc      <= '0;
            clk_out <= 1'b0;
        end else if (load) begin
            // a load wins over a terminal count on the same edge
            div_r   <= val;
            pc      <= '0;
            clk_out <= 1'b0;
        end else if (div_r == '0) begin
            pc      <= '0;
            clk_out <= 1'b0;
        end else if (pc == div_r - DIV_W'(1)) begin
            pc      <= '0;
            clk_out <= ~clk_out;
        end else begin
            pc      <= pc + DIV_W'(1);
        end
    end
endmodule

module clk_div_bank #(
    parameter int SIZE     = 8,
    parameter int NCH      = 2,
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              sample_in,
    input  logic              en,
    clk_div_bank_if.slave     bus,
    output logic [NCH-1:0]    clk_out,
    output logic [SIZE-1:0]   counter_out,
    output logic              snap_valid,
    output logic              overflow
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [SIZE-1:0] cnt;
    logic            s1, s2, s3;
    logic            rise;
    logic [NCH-1:0]  hit;

    assign rise = s2 & ~s3;

    // Counter, snapshot and sticky overflow. The capture takes the
    // pre-increment value, so a capture on the wrap edge stores all-ones.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            counter_out <= '0;
            snap_valid  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            s1         <= sample_in;
            s2         <= s1;
            s3         <= s2;
            snap_valid <= rise;
            if (rise)
                counter_out <= cnt;
            if (en) begin
                cnt <= cnt + SIZE'(1);
                if (cnt == {SIZE{1'b1}})
                    overflow <= 1'b1;
            end
        end
    end

    // Per-lane select decode: an out-of-range div_sel matches no lane,
    // so it loads nothing and raises no ack.
    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign hit[i] = bus.div_load && (bus.div_sel == SEL_W'(i));

        clk_div_lane #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT)
        ) u_lane (
            .clk_in  (clk_in),
            .rst     (rst),
            .load    (hit[i]),
            .val     (bus.div_val),
            .clk_out (clk_out[i])
        );
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            bus.div_ack <= 1'b0;
        else
            bus.div_ack <= |hit;
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank. Instance A (SIZE=8, NCH=3) covers
// capture, divider loads and reset abort; instance B (SIZE=4, NCH=2,
// DIV_W=4) covers counter wrap and the maximum divide ratio.
module tb_clk_div_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sample_a = 1'b0, en_a = 1'b0;
    logic [2:0] clk_out_a;
    logic [7:0] counter_out_a;
    logic       snap_a, ovf_a;

    logic       sample_b = 1'b0, en_b = 1'b0;
    logic [1:0] clk_out_b;
    logic [3:0] counter_out_b;
    logic       snap_b, ovf_b;

    clk_div_bank_if #(.NCH(3), .DIV_W(8)) bus_a ();
    clk_div_bank_if #(.NCH(2), .DIV_W(4)) bus_b ();

    clk_div_bank #(.SIZE(8), .NCH(3), .DIV_W(8), .DIV_INIT(1)) dut_a (
        .clk_in(clk), .rst(rst), .sample_in(sample_a), .en(en_a), .bus(bus_a),
        .clk_out(clk_out_a), .counter_out(counter_out_a),
        .snap_valid(snap_a), .overflow(ovf_a)
    );

    clk_div_bank #(.SIZE(4), .NCH(2), .DIV_W(4), .DIV_INIT(1)) dut_b (
        .clk_in(clk), .rst(rst), .sample_in(sample_b), .en(en_b), .bus(bus_b),
        .clk_out(clk_out_b), .counter_out(counter_out_b),
        .snap_valid(snap_b), .overflow(ovf_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       load;
        logic [1:0] sel;
        logic [7:0] val;
        logic [2:0] exp_clk;
        logic       exp_ack;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic setv(input int i, input logic ld, input logic [1:0] sel,
                        input logic [7:0] val, input logic [2:0] ec, input logic ea);
        tbl[i].load = ld;  tbl[i].sel = sel; tbl[i].val = val;
        tbl[i].exp_clk = ec; tbl[i].exp_ack = ea;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // row k = state after the k-th edge following reset release
        setv( 0, 0, 0, 0, 3'b111, 0);
        setv( 1, 1, 1, 3, 3'b000, 1);  // ch1 <- 3, ch1 clears
        setv( 2, 0, 0, 0, 3'b101, 0);
        setv( 3, 0, 0, 0, 3'b000, 0);
        setv( 4, 0, 0, 0, 3'b111, 0);  // ch1 rises after 3 low
        setv( 5, 0, 0, 0, 3'b010, 0);
        setv( 6, 0, 0, 0, 3'b111, 0);
        setv( 7, 0, 0, 0, 3'b000, 0);  // ch1 falls after 3 high
        setv( 8, 0, 0, 0, 3'b101, 0);
        setv( 9, 0, 0, 0, 3'b000, 0);
        setv(10, 0, 0, 0, 3'b111, 0);
        setv(11, 1, 0, 0, 3'b010, 1);  // ch0 <- 0, disabled
        setv(12, 0, 0, 0, 3'b110, 0);
        setv(13, 1, 3, 5, 3'b000, 0);  // out-of-range select
        setv(14, 0, 0, 0, 3'b100, 0);
        setv(15, 0, 0, 0, 3'b000, 0);
        setv(16, 0, 0, 0, 3'b110, 0);
        setv(17, 1, 2, 2, 3'b010, 1);  // held load on ch2
        setv(18, 1, 2, 2, 3'b010, 1);
        setv(19, 0, 0, 0, 3'b000, 0);
        setv(20, 0, 0, 0, 3'b100, 0);
        setv(21, 0, 0, 0, 3'b100, 0);
        setv(22, 0, 0, 0, 3'b010, 0);
        setv(23, 0, 0, 0, 3'b010, 0);
        setv(24, 1, 2, 1, 3'b010, 1);  // load beats ch2 terminal count
        setv(25, 0, 0, 0, 3'b100, 0);

        bus_a.div_load = 0; bus_a.div_sel = 0; bus_a.div_val = 0;
        bus_b.div_load = 0; bus_b.div_sel = 0; bus_b.div_val = 0;

        // reset state
        step(); step();
        chk("rst_clk", 0, clk_out_a, 0);
        chk("rst_cnt", 0, counter_out_a, 0);
        chk("rst_snap", 0, snap_a, 0);
        chk("rst_ovf", 0, ovf_a, 0);
        chk("rst_ack", 0, bus_a.div_ack, 0);
        rst = 1'b0;

        // en=0: counter idle, ratio-1 channels toggle every edge
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("idle_clk", k, clk_out_a, (k % 2) ? 3'b111 : 3'b000);
        end
        chk("idle_cnt", 0, counter_out_a, 0);
        chk("idle_ovf", 0, ovf_a, 0);

        // capture: cnt=20 when sample goes high, stored on the third edge
        en_a = 1'b1;
        for (int k = 0; k < 20; k++) step();
        sample_a = 1'b1;
        step(); chk("cap_snap", 0, snap_a, 0);
        step(); chk("cap_snap", 1, snap_a, 0);
        step(); chk("cap_snap", 2, snap_a, 1);
        chk("cap_val", 0, counter_out_a, 22);
        for (int k = 3; k < 8; k++) begin
            step(); chk("cap_snap", k, snap_a, 0);
        end
        chk("cap_hold", 0, counter_out_a, 22);
        en_a = 1'b0;

        // reset while a capture and a load are in flight
        sample_a = 1'b0;
        step(); step(); step();
        sample_a = 1'b1;
        step();
        bus_a.div_load = 1; bus_a.div_sel = 1; bus_a.div_val = 3;
        step();
        chk("abort_preack", 0, bus_a.div_ack, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_cnt", 0, counter_out_a, 0);
        chk("abort_ack", 0, bus_a.div_ack, 0);
        chk("abort_clk", 0, clk_out_a, 0);
        chk("abort_snap", 0, snap_a, 0);
        sample_a = 1'b0;
        bus_a.div_load = 0;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("abort_post_snap", k, snap_a, 0);
            chk("abort_post_ack", k, bus_a.div_ack, 0);
            chk("abort_post_clk", k, clk_out_a, (k % 2) ? 3'b111 : 3'b000);
        end

        // divider load table
        do_reset();
        for (int i = 0; i < NV; i++) begin
            bus_a.div_load = tbl[i].load;
            bus_a.div_sel  = tbl[i].sel;
            bus_a.div_val  = tbl[i].val;
            step();
            chk("tbl_clk", i + 1, clk_out_a, tbl[i].exp_clk);
            chk("tbl_ack", i + 1, bus_a.div_ack, tbl[i].exp_ack);
        end
        bus_a.div_load = 0;

        // SIZE=4 wrap with a capture on the wrap edge
        do_reset();
        en_b = 1'b1;
        for (int k = 1; k <= 13; k++) step();
        sample_b = 1'b1;
        step();
        step();
        chk("wrap_ovf_pre", 0, ovf_b, 0);
        chk("wrap_snap_pre", 0, snap_b, 0);
        step();
        chk("wrap_ovf", 0, ovf_b, 1);
        chk("wrap_snap", 0, snap_b, 1);
        chk("wrap_cap", 0, counter_out_b, 15);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("wrap_ovf_sticky", k, ovf_b, 1);
            chk("wrap_snap_once", k, snap_b, 0);
        end
        en_b = 1'b0;
        sample_b = 1'b0;

        // maximum ratio 15 on a 4-bit divider: period 30
        bus_b.div_load = 1; bus_b.div_sel = 1; bus_b.div_val = 4'hF;
        step();
        bus_b.div_load = 0;
        chk("max_ack", 0, bus_b.div_ack, 1);
        chk("max_clk", 0, clk_out_b[1], 0);
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("max_clk", k, clk_out_b[1], (k >= 15 && k < 30) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, which sets the width of the free-running counter and of its snapshot.
REQ-002 The block SHALL have parameter NCH, default 2, which sets the number of divided-clock channels (1..16).
REQ-003 The block SHALL have parameter DIV_W, default 8, which sets the width of each channel's divide ratio.
REQ-004 The block SHALL have parameter DIV_INIT, default 1, which sets each channel's divide ratio after reset.
REQ-005 The block SHALL have exactly one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk_in.
REQ-006 The block SHALL have port clk_in, input, width 1: the single clock.
REQ-007 The block SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-008 The block SHALL have port sample_in, input, width 1: asynchronous snapshot request; a rising edge triggers a capture.
REQ-009 The block SHALL have port en, input, width 1: count enable for the free-running counter.
REQ-010 The block SHALL have port div_load, input, width 1: single-cycle divide-ratio load strobe.
REQ-011 The block SHALL have port div_sel, input, width max(1,clog2(NCH)): channel index for a load.
REQ-012 The block SHALL have port div_val, input, width DIV_W: new divide ratio for a load.
REQ-013 The block SHALL have port div_ack, output, width 1: load-accepted pulse.
REQ-014 The block SHALL have port clk_out, output, width NCH: registered divided clocks, one bit per channel.
REQ-015 The block SHALL have port counter_out, output, width SIZE: last captured counter value.
REQ-016 The block SHALL have port snap_valid, output, width 1: one-cycle pulse marking a new counter_out.
REQ-017 The block SHALL have port overflow, output, width 1: sticky flag for counter wrap.

Function
REQ-018 The internal counter cnt SHALL increment by 1 on each clk_in edge where en=1, hold its value when en=0, and wrap from 2^SIZE-1 to 0.
REQ-019 On a wrap of cnt, overflow SHALL set to 1 on that same edge and SHALL stay 1 until reset.
REQ-020 sample_in SHALL pass through a 2-flop synchroniser (s1, s2) followed by a history flop s3; a rise is detected when s2=1 and s3=0.
REQ-021 On the edge where a rise is detected, counter_out SHALL load cnt's pre-increment value, and snap_valid SHALL be 1 for exactly the following cycle.
REQ-022 sample_in going high before edge k SHALL produce a capture at edge k+2, with snap_valid high from k+2 to k+3; a level held high SHALL produce only one capture.
REQ-023 A capture that coincides with a wrap SHALL store 2^SIZE-1, and overflow SHALL set on that same edge.
REQ-024 Each channel i SHALL hold a ratio register div_r[i], a phase counter pc[i] and the output clk_out[i].
REQ-025 If div_r[i]=0, clk_out[i] SHALL be held at 0 and pc[i] held at 0, disabling the channel.
REQ-026 If div_r[i]=N>0, pc[i] SHALL increment each cycle; when pc[i]=N-1, pc[i] SHALL reset to 0 and clk_out[i] SHALL toggle.
REQ-027 With div_r[i]=N>0, clk_out[i] SHALL run at 50% duty cycle with a period of 2N clk_in cycles (N=1 gives clk_in/2).
REQ-028 On an edge with div_load=1 and div_sel<NCH, div_r[div_sel] SHALL load div_val, pc[div_sel] and clk_out[div_sel] SHALL clear to 0, and div_ack SHALL be 1 for the next cycle only.
REQ-029 On an edge with div_load=1 and div_sel>=NCH, the load SHALL be ignored, with no state change and no div_ack.
REQ-030 If a load and a terminal count occur on the same edge of the same channel, the load SHALL take precedence.
REQ-031 A load SHALL leave all other channels unaffected.
REQ-032 A div_load held high for several cycles SHALL be treated as a load on every one of those edges.
REQ-033 Divide-ratio arithmetic SHALL be unsigned DIV_W-bit, and ratio 2^DIV_W-1 SHALL be supported.

Reset
REQ-034 When rst=1, the block SHALL immediately and asynchronously set cnt, counter_out, snap_valid, overflow, div_ack, clk_out, every pc[i] and s1, s2, s3 to 0, and set every div_r[i] to DIV_INIT.
REQ-035 Reset asserted mid-operation SHALL abort any capture or load in progress; no snap_valid or div_ack SHALL follow the deassertion of rst.
REQ-036 The first counter increment after reset deassertion SHALL occur on the first clk_in edge with en=1.

Verification
REQ-037 Reset with defaults, en=0 for 10 cycles -> counter_out=0, clk_out toggling every cycle (period 2), overflow=0.
REQ-038 en=1, sample_in rising after 20 counted cycles -> snap_valid is a single pulse 2 edges later, counter_out=21 or 22 per REQ-022, and a held level produces no second pulse.
REQ-039 Load ch1 with 3 while ch0 runs at ratio 1 -> div_ack pulses once, clk_out[1]=0 immediately, then period 6 (3 high, 3 low), and ch0 phase is undisturbed.
REQ-040 Load ratio 0 on ch0, then div_sel=NCH -> clk_out[0] stuck at 0, and the second load produces no ack and no change.
REQ-041 SIZE=4, en=1 for 16 cycles -> overflow=1 on the wrap edge and stays 1, and a capture on the wrap edge stores 15.
REQ-042 Assert rst during a pending sample edge and during a load -> all outputs 0, div_r=DIV_INIT, and no snap_valid or div_ack after release.
